// File: rtl/mem_port_arbiter_if.sv
// Requestor-side handshake bundle for mem_port_arbiter: per-port request lanes
// plus the tagged one-cycle-later response strobe and shared read-data bus.
interface mem_port_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32
);
  logic [N_PORTS-1:0]                req_valid;
  logic [N_PORTS-1:0]                req_ready;
  logic [N_PORTS-1:0]                req_wen;
  logic [N_PORTS-1:0][ADDR_W-1:0]    req_addr;
  logic [N_PORTS-1:0][DATA_W-1:0]    req_wdata;
  logic [N_PORTS-1:0][DATA_W/8-1:0]  req_wstrb;
  logic [N_PORTS-1:0]                resp_valid;
  logic [DATA_W-1:0]                 resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-port valid/ready arbiter in front of the shared memory data port.
// Define MEM_ARB_RR_EN for round-robin; otherwise fixed priority (port 0 highest).
module mem_port_arb_lane #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                  gnt,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [ADDR_W-1:0]     addr_g,
  output logic [DATA_W-1:0]     wdata_g,
  output logic [DATA_W/8-1:0]   wen_g
);
  // Ungranted lanes contribute zero so the memory bus is a plain OR.
  assign addr_g  = gnt ? addr : '0;
  assign wdata_g = gnt ? wdata : '0;
  assign wen_g   = (gnt && wen) ? wstrb : '0;
endmodule

module mem_port_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 32
) (
  input  logic                 riscv_cpu_clk,
  input  logic                 riscv_cpu_resetn,
  input  logic                 host_lock,
  mem_port_arbiter_if.slave    req,
  output logic                 mem_en,
  output logic [DATA_W/8-1:0]  mem_wen,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [CNT_W-1:0]     contention_cnt
);
  localparam int STRB_W = DATA_W/8;
  localparam int PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int STAGES = 1;

  logic [N_PORTS-1:0]             elig, gnt;
  logic [PTR_W-1:0]               gnt_idx, resp_port_q;
  logic                           found, multi;
  int                             idx;
  logic [STAGES:1]                vld_q;
  logic [STAGES:0]                vld_pipe;
  logic [N_PORTS-1:0][ADDR_W-1:0] lane_addr;
  logic [N_PORTS-1:0][DATA_W-1:0] lane_wdata;
  logic [N_PORTS-1:0][STRB_W-1:0] lane_wen;

  // host_lock masks everything but port 0 out of eligibility.
  assign elig  = req.req_valid & ({N_PORTS{~host_lock}} | N_PORTS'(1));
  assign multi = |(elig & (elig - N_PORTS'(1)));

`ifdef MEM_ARB_RR_EN
  logic [PTR_W-1:0] ptr;

  always_ff @(posedge riscv_cpu_clk or negedge riscv_cpu_resetn) begin
    if (!riscv_cpu_resetn)
      ptr <= '0;
    else if (found)
      ptr <= (gnt_idx == PTR_W'(N_PORTS-1)) ? '0 : gnt_idx + PTR_W'(1);
  end
`endif

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_PORTS; i++) begin
`ifdef MEM_ARB_RR_EN
      idx = (int'(ptr) + i) % N_PORTS;
`else
      idx = i;
`endif
      if (!found && elig[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
      end
    end
  end

  assign req.req_ready = gnt;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_lane
    mem_port_arb_lane #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lane (
      .gnt     (gnt[p]),
      .wen     (req.req_wen[p]),
      .addr    (req.req_addr[p]),
      .wdata   (req.req_wdata[p]),
      .wstrb   (req.req_wstrb[p]),
      .addr_g  (lane_addr[p]),
      .wdata_g (lane_wdata[p]),
      .wen_g   (lane_wen[p])
    );
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      mem_addr  = mem_addr  | lane_addr[p];
      mem_wdata = mem_wdata | lane_wdata[p];
      mem_wen   = mem_wen   | lane_wen[p];
    end
  end

  assign mem_en   = found;
  assign vld_pipe = {vld_q, found};

  always_ff @(posedge riscv_cpu_clk or negedge riscv_cpu_resetn) begin
    if (!riscv_cpu_resetn) begin
      vld_q       <= '0;
      resp_port_q <= '0;
    end else begin
      vld_q       <= vld_pipe[STAGES-1:0];
      resp_port_q <= gnt_idx;
    end
  end

  assign req.resp_valid = vld_pipe[STAGES] ? (N_PORTS'(1) << resp_port_q) : '0;
  assign req.resp_rdata = vld_pipe[STAGES] ? mem_rdata : '0;

  always_ff @(posedge riscv_cpu_clk or negedge riscv_cpu_resetn) begin
    if (!riscv_cpu_resetn)
      contention_cnt <= '0;
    else if (multi && (contention_cnt != '1))
      contention_cnt <= contention_cnt + CNT_W'(1);
  end
endmodule
